branch_predictor: RTL and testbench

//  Fetch-side direct-mapped BTB plus 2-bit bimodal predictor. Supplies predict_taken/predict_target,

---
 rtl/branch_predictor_pkg.sv | 35 +++
 rtl/branch_predictor_if.sv | 35 +++
 rtl/branch_predictor_table.sv | 74 +++++++
 rtl/branch_predictor.sv | 84 ++++++++
 tb/tb_branch_predictor.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_predictor_pkg.sv
// Purpose: shared types and helpers for the branch predictor.
//   bp_entry_t    : one table entry as seen by the lookup port
//                   (tag/target fields are sized for the widest supported PC
//                   and zero-extended when ADDR_WIDTH is narrower)
//   SNT/WNT/WT/ST : 2-bit bimodal counter states
//   sat_ctr_next  : saturating counter step
//   entry_taken   : direction an entry predicts, assuming it hit
package bp_pkg;

   localparam int BP_MAX_AW = 32;

   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   typedef struct packed {
      logic                 valid;
      logic [BP_MAX_AW-1:0] tag;
      logic [BP_MAX_AW-1:0] target;
      logic                 is_jump;
      logic [1:0]           ctr;
   } bp_entry_t;

   function automatic logic [1:0] sat_ctr_next(input logic [1:0] ctr, input logic taken);
      if (taken) return (ctr == ST)  ? ST  : ctr + 2'b01;
      else       return (ctr == SNT) ? SNT : ctr - 2'b01;
   endfunction

   // Jumps are always taken while resident; branches follow the counter MSB.
   function automatic logic entry_taken(input bp_entry_t e);
      return e.is_jump | e.ctr[1];
   endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Purpose: fetch / prediction / update signal bundle of the branch predictor.
//   master : fetch unit + branch resolution unit (drive fetch_* / flush / update_*)
//   slave  : branch_predictor (drives pred_*)
// Handshake: there is no ready. fetch_valid and update_valid each qualify their
// payload for exactly the cycle they are high; pred_valid qualifies pred_* and
// stays high while fetch_stall holds the outputs.
interface branch_predictor_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  fetch_valid;
   logic [ADDR_WIDTH-1:0] fetch_pc;
   logic                  fetch_stall;
   logic                  flush;
   logic                  pred_valid;
   logic [ADDR_WIDTH-1:0] pred_pc;
   logic                  pred_taken;
   logic [ADDR_WIDTH-1:0] pred_target;
   logic                  update_valid;
   logic [ADDR_WIDTH-1:0] update_pc;
   logic                  update_actual_taken;
   logic [ADDR_WIDTH-1:0] update_actual_target;
   logic                  update_is_jump;

   modport master (
      output fetch_valid, fetch_pc, fetch_stall, flush,
      output update_valid, update_pc, update_actual_taken, update_actual_target, update_is_jump,
      input  pred_valid, pred_pc, pred_taken, pred_target
   );

   modport slave (
      input  fetch_valid, fetch_pc, fetch_stall, flush,
      input  update_valid, update_pc, update_actual_taken, update_actual_target, update_is_jump,
      output pred_valid, pred_pc, pred_taken, pred_target
   );
endinterface

// File: rtl/branch_predictor_table.sv
// Purpose: direct-mapped BTB + bimodal counter storage.
//   Read port : i_rd_idx -> o_rd_entry (combinational, pre-update contents)
//   Write port: i_wr_* applies one resolved branch/jump per cycle, doing its
//               own read-modify-write of the addressed entry.
//   valid/ctr/is_jump are async-reset; tag/target are plain storage.
module bp_table
   import bp_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int ENTRIES    = 64,
   parameter int IDX_W      = $clog2(ENTRIES),
   parameter int TAG_W      = ADDR_WIDTH - IDX_W - 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [IDX_W-1:0]      i_rd_idx,
   output bp_entry_t             o_rd_entry,
   input  logic                  i_wr_valid,
   input  logic [IDX_W-1:0]      i_wr_idx,
   input  logic [TAG_W-1:0]      i_wr_tag,
   input  logic                  i_wr_taken,
   input  logic [ADDR_WIDTH-1:0] i_wr_target,
   input  logic                  i_wr_is_jump
);

   logic                  r_valid   [ENTRIES];
   logic                  r_is_jump [ENTRIES];
   logic [1:0]            r_ctr     [ENTRIES];
   logic [TAG_W-1:0]      r_tag     [ENTRIES];
   logic [ADDR_WIDTH-1:0] r_target  [ENTRIES];

   logic w_wr_hit;

   always_comb begin
      o_rd_entry         = '0;
      o_rd_entry.valid   = r_valid[i_rd_idx];
      o_rd_entry.tag     = BP_MAX_AW'(r_tag[i_rd_idx]);
      o_rd_entry.target  = BP_MAX_AW'(r_target[i_rd_idx]);
      o_rd_entry.is_jump = r_is_jump[i_rd_idx];
      o_rd_entry.ctr     = r_ctr[i_rd_idx];
   end

   assign w_wr_hit = r_valid[i_wr_idx] && (r_tag[i_wr_idx] == i_wr_tag);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_valid[i]   <= 1'b0;
            r_is_jump[i] <= 1'b0;
            r_ctr[i]     <= WNT;
         end
      end else if (i_wr_valid) begin
         if (w_wr_hit) begin
            r_is_jump[i_wr_idx] <= i_wr_is_jump;
            if (!i_wr_is_jump)
               r_ctr[i_wr_idx] <= sat_ctr_next(r_ctr[i_wr_idx], i_wr_taken);
         end else if (i_wr_taken) begin
            r_valid[i_wr_idx]   <= 1'b1;
            r_is_jump[i_wr_idx] <= i_wr_is_jump;
            r_ctr[i_wr_idx]     <= WT;
         end
      end
   end

   // Tag/target change only on taken outcomes: a taken hit rewrites the same
   // tag, a taken miss allocates, and not-taken never touches them.
   always_ff @(posedge clk) begin
      if (i_wr_valid && i_wr_taken) begin
         r_tag[i_wr_idx]    <= i_wr_tag;
         r_target[i_wr_idx] <= i_wr_target;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Purpose: fetch-side BTB + 2-bit bimodal branch predictor, trained by the
// branch resolution unit.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : branch_predictor_if.slave (fetch request, registered prediction,
//           resolved-branch update)
// Lookup is one cycle: the table is read with fetch_pc and the result is
// registered. flush beats stall beats a new capture.
// ADDR_WIDTH must not exceed bp_pkg::BP_MAX_AW.
module branch_predictor
   import bp_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int ENTRIES    = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   branch_predictor_if.slave  bus
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;

   logic [IDX_W-1:0]      w_fetch_idx;
   logic [TAG_W-1:0]      w_fetch_tag;
   bp_entry_t             w_entry;
   logic                  w_hit;
   logic                  w_taken;
   logic [ADDR_WIDTH-1:0] w_target;

   logic                  r_pred_valid;
   logic [ADDR_WIDTH-1:0] r_pred_pc;
   logic                  r_pred_taken;
   logic [ADDR_WIDTH-1:0] r_pred_target;

   assign w_fetch_idx = bus.fetch_pc[IDX_W+1:2];
   assign w_fetch_tag = bus.fetch_pc[ADDR_WIDTH-1:IDX_W+2];

   bp_table #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .ENTRIES    (ENTRIES)
   ) u_table (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_rd_idx     (w_fetch_idx),
      .o_rd_entry   (w_entry),
      .i_wr_valid   (bus.update_valid),
      .i_wr_idx     (bus.update_pc[IDX_W+1:2]),
      .i_wr_tag     (bus.update_pc[ADDR_WIDTH-1:IDX_W+2]),
      .i_wr_taken   (bus.update_actual_taken),
      .i_wr_target  (bus.update_actual_target),
      .i_wr_is_jump (bus.update_is_jump)
   );

   assign w_hit    = w_entry.valid && (w_entry.tag == BP_MAX_AW'(w_fetch_tag));
   assign w_taken  = w_hit && entry_taken(w_entry);
   // Fall-through wraps modulo 2**ADDR_WIDTH.
   assign w_target = w_taken ? w_entry.target[ADDR_WIDTH-1:0]
                             : bus.fetch_pc + ADDR_WIDTH'(4);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pred_valid  <= 1'b0;
         r_pred_pc     <= '0;
         r_pred_taken  <= 1'b0;
         r_pred_target <= '0;
      end else if (bus.flush) begin
         r_pred_valid  <= 1'b0;
      end else if (!bus.fetch_stall) begin
         r_pred_valid  <= bus.fetch_valid;
         if (bus.fetch_valid) begin
            r_pred_pc     <= bus.fetch_pc;
            r_pred_taken  <= w_taken;
            r_pred_target <= w_target;
         end
      end
   end

   assign bus.pred_valid  = r_pred_valid;
   assign bus.pred_pc     = r_pred_pc;
   assign bus.pred_taken  = r_pred_taken;
   assign bus.pred_target = r_pred_target;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic        t;
    logic [31:0] tgt;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  rec_t exp_q[$];

  branch_predictor_if #(.ADDR_WIDTH(32)) bus();

  branch_predictor #(.ADDR_WIDTH(32), .ENTRIES(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // A table of 64 slots keyed by pc[7:2]; each remembers who owns it, where it
  // last went when taken, whether it is a jump, and a confidence count 0..3.
  bit          m_valid [64];
  logic [23:0] m_tag   [64];
  logic [31:0] m_tgt   [64];
  bit          m_jump  [64];
  int          m_conf  [64];
  rec_t        held;

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0;
      m_jump[i]  = 0;
      m_conf[i]  = 1;
    end
    held = '0;
  endtask

  function automatic rec_t model_predict(input logic [31:0] pc);
    rec_t r;
    int   idx;
    bit   hit;
    idx   = int'(pc[7:2]);
    hit   = m_valid[idx] && (m_tag[idx] == pc[31:8]);
    r.v   = 1'b1;
    r.pc  = pc;
    r.t   = hit && (m_jump[idx] || m_conf[idx] >= 2);
    r.tgt = r.t ? m_tgt[idx] : pc + 32'd4;
    return r;
  endfunction

  task automatic model_update(input logic [31:0] pc, input bit taken,
                              input logic [31:0] tgt, input bit jump);
    int idx;
    bit hit;
    idx = int'(pc[7:2]);
    hit = m_valid[idx] && (m_tag[idx] == pc[31:8]);
    if (hit) begin
      m_jump[idx] = jump;
      if (taken) m_tgt[idx] = tgt;
      if (!jump) begin
        if (taken) m_conf[idx] = (m_conf[idx] < 3) ? m_conf[idx] + 1 : 3;
        else       m_conf[idx] = (m_conf[idx] > 0) ? m_conf[idx] - 1 : 0;
      end
    end else if (taken) begin
      m_valid[idx] = 1;
      m_tag[idx]   = pc[31:8];
      m_tgt[idx]   = tgt;
      m_jump[idx]  = jump;
      m_conf[idx]  = 2;
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one record per clock edge the driver issued; sampled 2ns after the edge.
  initial begin
    rec_t r;
    forever begin
      @(posedge clk);
      #2;
      if (rst_n && exp_q.size() > 0) begin
        r = exp_q.pop_front();
        if (!r.v)
          check("pred_valid_low", 68'(bus.pred_valid), 68'(1'b0));
        else
          check("pred", 68'({bus.pred_valid, bus.pred_pc, bus.pred_taken, bus.pred_target}), 68'(r));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive_idle();
    bus.fetch_valid          = 1'b0;
    bus.fetch_pc             = '0;
    bus.fetch_stall          = 1'b0;
    bus.flush                = 1'b0;
    bus.update_valid         = 1'b0;
    bus.update_pc            = '0;
    bus.update_actual_taken  = 1'b0;
    bus.update_actual_target = '0;
    bus.update_is_jump       = 1'b0;
  endtask

  // One clock of stimulus; pushes the expected prediction for the following edge.
  task automatic step(input bit fv, input logic [31:0] pc, input bit st, input bit fl,
                      input bit uv, input logic [31:0] upc, input bit ut,
                      input logic [31:0] utgt, input bit uj);
    rec_t r;
    @(negedge clk);
    bus.fetch_valid          = fv;
    bus.fetch_pc             = pc;
    bus.fetch_stall          = st;
    bus.flush                = fl;
    bus.update_valid         = uv;
    bus.update_pc            = upc;
    bus.update_actual_taken  = ut;
    bus.update_actual_target = utgt;
    bus.update_is_jump       = uj;
    if (fl) begin
      held.v = 1'b0;
    end else if (!st) begin
      if (fv) held = model_predict(pc);
      else    held.v = 1'b0;
    end
    r = held;
    if (uv) model_update(upc, ut, utgt, uj);
    exp_q.push_back(r);
  endtask

  task automatic fetch(input logic [31:0] pc);
    step(1, pc, 0, 0, 0, 32'h0, 0, 32'h0, 0);
  endtask

  task automatic upd(input logic [31:0] pc, input bit t, input logic [31:0] tgt, input bit j);
    step(0, 32'h0, 0, 0, 1, pc, t, tgt, j);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"},  68'(bus.pred_valid),  68'(1'b0));
    check({tag, "_pc"},     68'(bus.pred_pc),     68'(32'h0));
    check({tag, "_taken"},  68'(bus.pred_taken),  68'(1'b0));
    check({tag, "_target"}, 68'(bus.pred_target), 68'(32'h0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rpc;
    drive_idle();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // basic miss
    fetch(32'h100);
    // allocate then retrain
    upd(32'h100, 1, 32'h80, 0);
    fetch(32'h100);
    upd(32'h100, 0, 32'h0, 0);
    fetch(32'h100);
    // saturation: up to strongly taken, then down
    repeat (4) upd(32'h100, 1, 32'h80, 0);
    upd(32'h100, 0, 32'h0, 0);
    fetch(32'h100);
    repeat (2) upd(32'h100, 0, 32'h0, 0);
    fetch(32'h100);
    // alias on the same index
    fetch(32'h200);
    upd(32'h200, 1, 32'h300, 0);
    fetch(32'h100);
    fetch(32'h200);
    // jump, then same-edge lookup/update
    upd(32'h40, 1, 32'h400, 1);
    fetch(32'h40);
    step(1, 32'h44, 0, 0, 1, 32'h44, 1, 32'h500, 1);
    fetch(32'h44);
    // fall-through wraps
    fetch(32'hFFFF_FFFC);
    // stall holds, flush overrides stall
    fetch(32'h40);
    repeat (3) step(1, 32'h100, 1, 0, 0, 32'h0, 0, 32'h0, 0);
    step(1, 32'h100, 1, 1, 0, 32'h0, 0, 32'h0, 0);
    step(0, 32'h0, 1, 0, 0, 32'h0, 0, 32'h0, 0);
    fetch(32'h40);

    // mid-run reset: outputs drop immediately, table forgets
    @(posedge clk);
    #3;
    drive_idle();
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    model_reset();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    fetch(32'h40);
    fetch(32'h200);

    // randomized traffic over a small PC pool to force hits and aliasing
    for (int n = 0; n < 3000; n++) begin
      bit st, fl, fv, uv, ut, uj;
      logic [31:0] upc;
      rpc = {22'($urandom_range(0, 3)), 2'b00, 6'($urandom_range(0, 7)), 2'b00};
      upc = {22'($urandom_range(0, 3)), 2'b00, 6'($urandom_range(0, 7)), 2'b00};
      fv  = ($urandom_range(0, 3) != 0);
      st  = ($urandom_range(0, 7) == 0);
      fl  = ($urandom_range(0, 15) == 0);
      uv  = ($urandom_range(0, 1) == 1);
      ut  = ($urandom_range(0, 1) == 1);
      uj  = ($urandom_range(0, 3) == 0);
      step(fv, rpc, st, fl, uv, upc, ut, $urandom() & 32'hFFFF_FFFC, uj);
    end

    @(negedge clk);
    drive_idle();
    repeat (3) @(posedge clk);
    #3;
    check("queue_drained", 68'(exp_q.size()), 68'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
